// File: rtl/scope_pkg.sv
// Shared types and constants for the triggered scope capture block.
package scope_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_TRIG = 2'd1,
        ST_CAPTURE   = 2'd2,
        ST_DRAIN     = 2'd3
    } state_e;

    localparam logic EDGE_RISE = 1'b0;
    localparam logic EDGE_FALL = 1'b1;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned TMO_W = 16;
    localparam int unsigned DEC_W = 8;

endpackage

// File: rtl/scope_trig_detect.sv
// Level-crossing detector: keeps the previous valid sample and flags a
// rising or falling crossing of the threshold on the current sample.
module scope_trig_detect
    import scope_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_i,
    input  logic                  smp_vld_i,
    input  logic [DATA_WIDTH-1:0] smp_i,
    input  logic [DATA_WIDTH-1:0] level_i,
    input  logic                  edge_sel_i,
    output logic                  hit_c_o
);

    logic [DATA_WIDTH-1:0] prev_q;
    logic                  prev_vld_q;
    logic                  cross_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
        end else if (clr_i) begin
            prev_vld_q <= 1'b0;
        end else if (smp_vld_i) begin
            prev_q     <= smp_i;
            prev_vld_q <= 1'b1;
        end
    end

    always_comb begin
        cross_c = 1'b0;
        if (edge_sel_i == EDGE_RISE) begin
            cross_c = (prev_q < level_i) && (smp_i >= level_i);
        end else begin
            cross_c = (prev_q >= level_i) && (smp_i < level_i);
        end
    end

    // The first sample after a clear only primes the previous-sample register.
    assign hit_c_o = smp_vld_i & prev_vld_q & cross_c;

endmodule

// File: rtl/scope_trig_capture.sv
// Triggered sample capture into an external FIFO: waits for a level
// crossing (or auto timeout), then writes CAP_LEN decimated samples.
module scope_trig_capture
    import scope_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned CAP_LEN      = 1000,
    parameter int unsigned AUTO_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] adc_data,
    input  logic                  adc_valid,
    input  logic [DATA_WIDTH-1:0] trig_level,
    input  logic                  trig_edge,
    input  logic                  trig_auto,
    input  logic [DEC_W-1:0]      decim,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    input  logic                  wr_full,
    input  logic                  rd_empty,
    output logic                  busy,
    output logic                  done,
    output logic                  trig_forced,
    output logic                  overflow,
    output logic [CNT_W-1:0]      cap_cnt
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] level_q;
    logic                  edge_q;
    logic                  auto_q;
    logic [DEC_W-1:0]      decim_q;
    logic [TMO_W-1:0]      tmo_q;
    logic [DEC_W-1:0]      dec_q;
    logic                  pend_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [CNT_W-1:0]      cap_cnt_q;
    logic                  forced_q;
    logic                  ovf_q;

    logic arm_ok_c, smp_wait_c, det_hit_c, tmo_hit_c, trig_c;
    logic last_wr_c, dec_sel_c, sel_c;

    assign arm_ok_c   = (state_q == ST_IDLE) & arm & rd_empty & ~abort;
    assign smp_wait_c = (state_q == ST_WAIT_TRIG) & adc_valid;
    assign tmo_hit_c  = auto_q & (tmo_q == TMO_W'(AUTO_TIMEOUT));
    assign trig_c     = smp_wait_c & (det_hit_c | tmo_hit_c) & ~abort;

    scope_trig_detect #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_detect (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (arm_ok_c),
        .smp_vld_i  (smp_wait_c),
        .smp_i      (adc_data),
        .level_i    (level_q),
        .edge_sel_i (edge_q),
        .hit_c_o    (det_hit_c)
    );

    assign wr_en   = pend_q & ~wr_full & ~abort;
    assign wr_data = wr_data_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = (state_q == ST_DRAIN) & rd_empty & ~abort;
    assign trig_forced = forced_q;
    assign overflow    = ovf_q;
    assign cap_cnt     = cap_cnt_q;

    // The write that completes the capture also closes the selection window.
    assign last_wr_c = wr_en & (cap_cnt_q == CNT_W'(CAP_LEN - 1));
    assign dec_sel_c = (state_q == ST_CAPTURE) & adc_valid & (dec_q == decim_q)
                       & ~last_wr_c & ~abort;
    assign sel_c     = trig_c | dec_sel_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (arm_ok_c)  state_d = ST_WAIT_TRIG;
            ST_WAIT_TRIG: if (trig_c)    state_d = ST_CAPTURE;
            ST_CAPTURE:   if (last_wr_c) state_d = ST_DRAIN;
            ST_DRAIN:     if (rd_empty)  state_d = ST_IDLE;
            default:                     state_d = ST_IDLE;
        endcase
        if (abort) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q   <= '0;
            edge_q    <= EDGE_RISE;
            auto_q    <= 1'b0;
            decim_q   <= '0;
            tmo_q     <= '0;
            dec_q     <= '0;
            pend_q    <= 1'b0;
            wr_data_q <= '0;
            cap_cnt_q <= '0;
            forced_q  <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            pend_q <= sel_c;
            if (sel_c) begin
                wr_data_q <= adc_data;
            end
            if (arm_ok_c) begin
                level_q   <= trig_level;
                edge_q    <= trig_edge;
                auto_q    <= trig_auto;
                decim_q   <= decim;
                tmo_q     <= '0;
                cap_cnt_q <= '0;
                forced_q  <= 1'b0;
                ovf_q     <= 1'b0;
            end
            if (smp_wait_c && !trig_c && (tmo_q != TMO_W'(AUTO_TIMEOUT))) begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
            if (trig_c) begin
                dec_q <= '0;
                forced_q <= ~det_hit_c;
            end else if ((state_q == ST_CAPTURE) && adc_valid) begin
                dec_q <= (dec_q == decim_q) ? '0 : dec_q + DEC_W'(1);
            end
            if (wr_en) begin
                cap_cnt_q <= cap_cnt_q + CNT_W'(1);
            end
            if (pend_q && wr_full && !abort) begin
                ovf_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_scope_trig_capture.sv
// Bench for scope_trig_capture: per-cycle stimulus tables, a reference model
// of the capture rules, and a FIFO-write scoreboard checked by a monitor.
module tb_scope_trig_capture;

    localparam int unsigned DW  = 8;
    localparam int unsigned CAP = 16;
    localparam int unsigned TMO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic [DW-1:0] adc_data = '0;
    logic          adc_valid = 1'b0;
    logic [DW-1:0] trig_level = '0;
    logic          trig_edge = 1'b0;
    logic          trig_auto = 1'b0;
    logic [7:0]    decim = '0;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_full = 1'b0;
    logic          rd_empty = 1'b1;
    logic          busy;
    logic          done;
    logic          trig_forced;
    logic          overflow;
    logic [10:0]   cap_cnt;

    scope_trig_capture #(
        .DATA_WIDTH   (DW),
        .CAP_LEN      (CAP),
        .AUTO_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .arm         (arm),
        .abort       (abort),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .trig_level  (trig_level),
        .trig_edge   (trig_edge),
        .trig_auto   (trig_auto),
        .decim       (decim),
        .wr_data     (wr_data),
        .wr_en       (wr_en),
        .wr_full     (wr_full),
        .rd_empty    (rd_empty),
        .busy        (busy),
        .done        (done),
        .trig_forced (trig_forced),
        .overflow    (overflow),
        .cap_cnt     (cap_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  vectors = 0;
    int  errors = 0;
    int  exp_done_cyc = -1;
    int  done_seen = 0;
    bit  sb_en = 1'b1;

    // Stimulus table: index 0 is the arm cycle, the rest are sample cycles.
    bit         st_v[0:511];
    logic [7:0] st_d[0:511];
    bit         st_full[0:511];
    int         len = 0;
    logic [7:0] cfg_lvl;
    bit         cfg_edge;
    bit         cfg_auto;
    int         cfg_decim;

    always @(negedge clk) begin
        if (!rst && sb_en) begin
            if (wr_en) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wr_unexpected: cycle %0d data %02h, no write expected", cyc, wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.data !== wr_data) begin
                        errors++;
                        $display("FAIL wr_data: got %02h at cycle %0d, expected %02h at cycle %0d",
                                 wr_data, cyc, e.data, e.cyc);
                    end
                end
            end
            if (done) begin
                vectors++;
                done_seen++;
                if (cyc != exp_done_cyc) begin
                    errors++;
                    $display("FAIL done_cycle: got cycle %0d, expected %0d", cyc, exp_done_cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic new_stim(input logic [7:0] lvl, input bit edg, input bit aut, input int dec);
        cfg_lvl = lvl; cfg_edge = edg; cfg_auto = aut; cfg_decim = dec;
        st_v[0] = 1'b0; st_d[0] = '0; st_full[0] = 1'b0;
        len = 1;
    endtask

    task automatic add(input bit v, input logic [7:0] d, input bit f);
        st_v[len] = v; st_d[len] = d; st_full[len] = f;
        len++;
    endtask

    // Reference: walk the sample table applying the trigger, decimation,
    // drop and capture-length rules; pushes each expected FIFO write.
    task automatic model(input int base, input int n, output int nwr,
                         output bit ovf, output bit forced, output bit complete);
        bit         have_prev = 0;
        logic [7:0] prev = '0;
        int         cnt = 0;
        int         phase = 0;
        int         gap = 0;
        bit         pend = 0;
        int         pend_k = 0;
        nwr = 0; ovf = 0; forced = 0;
        for (int k = 1; k < n; k++) begin
            if (phase == 1 && pend) begin
                pend = 0;
                if (!st_full[k]) begin
                    wr_t e;
                    e.cyc = base + k;
                    e.data = st_d[pend_k];
                    exp_q.push_back(e);
                    nwr++;
                    if (nwr == int'(CAP)) phase = 2;
                end else begin
                    ovf = 1;
                end
            end
            if (phase == 0 && st_v[k]) begin
                bit hit = 0;
                if (have_prev) begin
                    if (!cfg_edge) hit = (prev < cfg_lvl) && (st_d[k] >= cfg_lvl);
                    else           hit = (prev >= cfg_lvl) && (st_d[k] < cfg_lvl);
                end
                if (!hit && cfg_auto && cnt == int'(TMO)) begin
                    hit = 1;
                    forced = 1;
                end
                if (!hit) cnt++;
                prev = st_d[k];
                have_prev = 1;
                if (hit) begin
                    phase = 1; gap = 0; pend = 1; pend_k = k;
                end
            end else if (phase == 1 && st_v[k]) begin
                gap++;
                if (gap == cfg_decim + 1) begin
                    gap = 0; pend = 1; pend_k = k;
                end
            end
        end
        complete = (phase == 2);
    endtask

    task automatic drive_idx(input int k);
        arm       = (k == 0);
        rd_empty  = (k == 0);
        abort     = 1'b0;
        adc_valid = st_v[k];
        adc_data  = st_d[k];
        wr_full   = st_full[k];
        if (k == 0) begin
            trig_level = cfg_lvl; trig_edge = cfg_edge;
            trig_auto = cfg_auto; decim = 8'(cfg_decim);
        end else begin
            trig_level = 8'($urandom); trig_edge = 1'($urandom);
            trig_auto = 1'($urandom); decim = 8'($urandom);
        end
    endtask

    task automatic run_capture(input string tag);
        int nwr, base, n;
        bit ovf, forced, complete;
        for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b0);
        n = len;
        @(posedge clk); #1;
        base = cyc;
        model(base, n, nwr, ovf, forced, complete);
        exp_done_cyc = complete ? base + n : -1;
        done_seen = 0;
        for (int k = 0; k < n; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            drive_idx(k);
        end
        @(posedge clk); #1;
        arm = 0; adc_valid = 0; wr_full = 0;
        rd_empty = complete; abort = !complete;
        @(posedge clk); #1;
        abort = 0; rd_empty = 1;
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_cap_cnt"}, int'(cap_cnt), nwr);
        chk({tag, "_overflow"}, int'(overflow), int'(ovf));
        chk({tag, "_forced"}, int'(trig_forced), int'(forced));
        chk({tag, "_done_count"}, done_seen, int'(complete));
        chk({tag, "_writes_left"}, exp_q.size(), 0);
        exp_q.delete();
        exp_done_cyc = -1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cap_cnt", int'(cap_cnt), 0);
        rst = 1'b0;
        chk("rst_wr_data", int'(wr_data), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_flags", int'({trig_forced, overflow}), 0);

        // Arm while the FIFO still holds data must be ignored.
        @(posedge clk); #1;
        arm = 1; rd_empty = 0;
        @(posedge clk); #1;
        arm = 0; rd_empty = 1;
        chk("arm_not_empty", int'(busy), 0);

        new_stim(8'h80, 1'b0, 1'b0, 0);
        for (int i = 0; i < 40; i++) add(1'b1, 8'(8'h70 + i), 1'b0);
        run_capture("ramp_d0");

        new_stim(8'h80, 1'b0, 1'b0, 3);
        for (int i = 0; i < 88; i++) add(1'b1, 8'(8'h70 + i), 1'b0);
        run_capture("ramp_d3");

        new_stim(8'h40, 1'b1, 1'b0, 0);
        for (int i = 0; i < 32; i++) add(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 48; i++) add(1'b1, 8'(8'h50 - i), 1'b0);
        run_capture("falling");

        new_stim(8'h80, 1'b0, 1'b1, 0);
        for (int i = 0; i < 40; i++) add(1'b1, 8'h10, 1'b0);
        run_capture("auto");

        new_stim(8'h80, 1'b0, 1'b0, 0);
        for (int i = 0; i < 50; i++) add(1'b1, 8'(8'h70 + i), (i == 19 || i == 21 || i == 22));
        run_capture("full_drop");

        new_stim(8'h80, 1'b0, 1'b0, 0);
        for (int i = 0; i < 21; i++) add(1'b1, 8'(8'h70 + i), 1'b0);
        for (int i = 0; i < 4; i++) add(1'b0, 8'h00, 1'b0);
        run_capture("abort5");

        // Asynchronous reset while writes are streaming.
        sb_en = 0;
        @(posedge clk); #1;
        arm = 1; rd_empty = 1; trig_level = 8'h80; trig_edge = 0; trig_auto = 0; decim = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            arm = 0; rd_empty = 0; adc_valid = 1; adc_data = 8'(8'h70 + i);
        end
        @(negedge clk);
        chk("pre_rst_wr_en", int'(wr_en), 1);
        #2 rst = 1;
        #1;
        chk("mid_rst_wr_en", int'(wr_en), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_cap_cnt", int'(cap_cnt), 0);
        adc_valid = 0; rd_empty = 1;
        @(negedge clk);
        rst = 0;
        sb_en = 1;

        for (int r = 0; r < 20; r++) begin
            bit aut = ($urandom_range(0, 3) == 0);
            bit quiet = aut && ($urandom_range(0, 1) == 1);
            new_stim(quiet ? 8'hF8 : 8'($urandom_range(8'h20, 8'hE0)), 1'($urandom),
                     aut, $urandom_range(0, 3));
            for (int i = 0; i < 200; i++) begin
                add(($urandom_range(0, 3) != 0),
                    quiet ? 8'($urandom_range(0, 8'hF0)) : 8'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) == 0));
            end
            run_capture("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/scope_trig_capture.md
SCOPE_TRIG_CAPTURE -- requirements
Module: scope_trig_capture

Interface
REQ-001 DATA_WIDTH, 8, sample width; equals p_fifo wr_data width.
REQ-002 CAP_LEN, 1000, samples written per capture; legal range 1..1024.
REQ-003 AUTO_TIMEOUT, 4096, valid samples counted in auto mode before a forced trigger; legal range 1..65535.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 arm  input  1  single-cycle capture start request.
REQ-007 abort  input  1  single-cycle capture cancel.
REQ-008 adc_data  input  DATA_WIDTH  unsigned ADC sample.
REQ-009 adc_valid  input  1  adc_data valid this cycle.
REQ-010 trig_level  input  DATA_WIDTH  unsigned trigger threshold.
REQ-011 trig_edge  input  1  0 = rising, 1 = falling.
REQ-012 trig_auto  input  1  1 = auto mode (forced trigger on timeout).
REQ-013 decim  input  8  keep one of every decim+1 valid samples after the trigger.
REQ-014 wr_data  output  DATA_WIDTH  to p_fifo wr_data.
REQ-015 wr_en  output  1  to p_fifo wr_en.
REQ-016 wr_full  input  1  from p_fifo wr_full.
REQ-017 rd_empty  input  1  from p_fifo rd_empty.
REQ-018 busy  output  1  high whenever state is not IDLE.
REQ-019 done  output  1  one-cycle pulse on capture completion.
REQ-020 trig_forced  output  1  sticky: current/last capture was auto-triggered.
REQ-021 overflow  output  1  sticky: at least one selected sample was dropped.
REQ-022 cap_cnt  output  11  samples written in current/last capture.

Function
REQ-023 FSM states IDLE, WAIT_TRIG, CAPTURE, DRAIN shall exist; no other reachable states.
REQ-024 IDLE->WAIT_TRIG on arm with rd_empty high; arm otherwise ignored; on acceptance trig_level/trig_edge/trig_auto/decim are latched, cap_cnt, trig_forced, overflow cleared; later input changes have no effect until the next arm.
REQ-025 Detector keeps previous valid sample; first valid sample after arm only loads it. Rising: prev < level and cur >= level; falling: prev >= level and cur < level; unsigned compare.
REQ-026 Auto mode: counter increments per valid sample in WAIT_TRIG; once count equals AUTO_TIMEOUT with no trigger, the next valid sample is the trigger and trig_forced is set.
REQ-027 Trigger sample is the first selected sample; WAIT_TRIG->CAPTURE on that cycle; decimation counter cleared there; thereafter every (decim+1)th valid sample is selected.
REQ-028 Selected sample is registered into wr_data with a pending flag; wr_en = pending AND NOT wr_full, asserted the cycle after selection, one cycle per sample; decim=0 with continuous adc_valid gives back-to-back wr_en.
REQ-029 If wr_full is high while pending, sample is dropped, overflow set, cap_cnt not incremented.
REQ-030 cap_cnt increments on each wr_en; CAPTURE->DRAIN in the cycle cap_cnt reaches CAP_LEN; no further selection.
REQ-031 DRAIN->IDLE when rd_empty high; done pulses exactly that cycle.
REQ-032 abort in any state -> IDLE next cycle, pending write cancelled, no done; abort overrides arm in the same cycle.

Reset
REQ-033 rst shall asynchronously force IDLE, clear pending, counters, prev-valid flag, and drive wr_en, wr_data, busy, done, trig_forced, overflow, cap_cnt to 0, including mid-capture.

Structure
REQ-034 Shared package scope_pkg shall hold the FSM state encoding and the trig_edge constants EDGE_RISE=0, EDGE_FALL=1.
REQ-035 Edge comparator plus previous-sample register shall be sub-module scope_trig_detect.

Verification
REQ-036 CAP_LEN=16, decim=0, rising, level 0x80, ramp 0x70 upward -> 16 writes 0x80..0x8F, first wr_en one cycle after 0x80 valid, done when rd_empty=1.
REQ-037 Same stimulus, decim=3 -> writes 0x80, 0x84, 0x88 ... 0xBC, cap_cnt=16.
REQ-038 Falling, level 0x40, ramp up past 0x40 then down -> no write on upward crossing; first write 0x3F.
REQ-039 Auto, AUTO_TIMEOUT=8, constant 0x10 -> 9th valid sample is first write, trig_forced=1.
REQ-040 wr_full high during 3 pending writes -> 3 samples absent from FIFO, overflow=1, capture still ends at cap_cnt=CAP_LEN.
REQ-041 abort after 5 writes, then rst mid-capture on re-arm -> wr_en low next cycle / immediately, IDLE, no done, cap_cnt 5 then 0.
